// File: rtl/seven_segment_fun.sv
// ---------------------------------------------------------------------------
// seven_segment_fun
//
// Animated single-digit 7-segment display driver (TinyTapeout user tile).
// Shows a static hex digit, a free-running hex counter, a ring chase or a
// figure-8 snake, selected by ui_in[7:6]. The animation rate comes from a
// power-of-two prescaler whose step period is 2^(DIV_BASE+speed) clocks.
//
// Ports:
//   clk      : system clock, single domain
//   rst_n    : synchronous active-low reset
//   ena      : tile enable, ignored
//   ui_in    : [7:6] mode, [5:4] speed, [3:0] static hex digit
//   uo_out   : [6:0] segments a..g (bit0 = a), [7] heartbeat decimal point
//   uio_in   : unused
//   uio_out  : constant 0x00
//   uio_oe   : constant 0x00 (all bidirectional pins are inputs)
// ---------------------------------------------------------------------------
module seven_segment_fun #(
    parameter int DIV_BASE = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PW = DIV_BASE + 3;
    localparam logic [PW-1:0] PRE_ONES = '1;
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'b00,
        MODE_COUNTER = 2'b01,
        MODE_RING    = 2'b10,
        MODE_SNAKE   = 2'b11
    } mode_t;

    logic [PW-1:0] pre;
    logic [3:0]    step;
    mode_t         mode_q;
    logic          dp;
    logic [6:0]    seg_q;

    mode_t         mode_in;
    logic [1:0]    speed;
    logic [3:0]    digit;
    logic [PW-1:0] mask;
    logic          tick;
    logic [3:0]    step_next;
    logic [6:0]    pattern;

    // Tie-off so the ignored inputs are visibly consumed.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in};

    assign mode_in = mode_t'(ui_in[7:6]);
    assign speed   = ui_in[5:4];
    assign digit   = ui_in[3:0];

    // The mask keeps the low DIV_BASE+speed bits of the prescaler; a tick
    // fires when all of them are ones. Speed is read live, so a speed change
    // takes effect on the very next comparison without touching pre.
    always_comb begin
        mask = PRE_ONES >> (2'd3 - speed);
        tick = ((pre & mask) == mask);
    end

    // Next animation step for the current mode; each animation wraps at the
    // length of its own sequence.
    always_comb begin
        step_next = 4'd0;
        case (mode_q)
            MODE_STATIC:  step_next = 4'd0;
            MODE_COUNTER: step_next = step + 4'd1;
            MODE_RING:    step_next = (step == 4'd5) ? 4'd0 : step + 4'd1;
            MODE_SNAKE:   step_next = (step == 4'd7) ? 4'd0 : step + 4'd1;
            default:      step_next = 4'd0;
        endcase
    end

    // Segment pattern from the registered mode and step. Static mode decodes
    // the live digit; the counter decodes the step itself.
    always_comb begin
        logic [3:0] hex_val;
        hex_val = (mode_q == MODE_STATIC) ? digit : step;
        pattern = 7'h00;
        case (mode_q)
            MODE_STATIC, MODE_COUNTER: begin
                case (hex_val)
                    4'h0: pattern = 7'h3F;
                    4'h1: pattern = 7'h06;
                    4'h2: pattern = 7'h5B;
                    4'h3: pattern = 7'h4F;
                    4'h4: pattern = 7'h66;
                    4'h5: pattern = 7'h6D;
                    4'h6: pattern = 7'h7D;
                    4'h7: pattern = 7'h07;
                    4'h8: pattern = 7'h7F;
                    4'h9: pattern = 7'h6F;
                    4'hA: pattern = 7'h77;
                    4'hB: pattern = 7'h7C;
                    4'hC: pattern = 7'h39;
                    4'hD: pattern = 7'h5E;
                    4'hE: pattern = 7'h79;
                    default: pattern = 7'h71;
                endcase
            end
            MODE_RING: begin
                case (step)
                    4'd0:    pattern = 7'h01;
                    4'd1:    pattern = 7'h02;
                    4'd2:    pattern = 7'h04;
                    4'd3:    pattern = 7'h08;
                    4'd4:    pattern = 7'h10;
                    4'd5:    pattern = 7'h20;
                    default: pattern = 7'h00;
                endcase
            end
            MODE_SNAKE: begin
                case (step)
                    4'd0:    pattern = 7'h01;
                    4'd1:    pattern = 7'h02;
                    4'd2:    pattern = 7'h40;
                    4'd3:    pattern = 7'h10;
                    4'd4:    pattern = 7'h08;
                    4'd5:    pattern = 7'h04;
                    4'd6:    pattern = 7'h40;
                    default: pattern = 7'h20;
                endcase
            end
            default: pattern = 7'h00;
        endcase
    end

    // Main state update. A mode change restarts the animation and the
    // prescaler and takes priority over a coincident tick, so dp holds.
    // seg_q always loads the pattern of the pre-edge state, which puts the
    // display one edge behind a step update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre    <= '0;
            step   <= 4'd0;
            mode_q <= MODE_STATIC;
            dp     <= 1'b0;
            seg_q  <= 7'h00;
        end else begin
            seg_q <= pattern;
            if (mode_in != mode_q) begin
                mode_q <= mode_in;
                step   <= 4'd0;
                pre    <= '0;
            end else begin
                pre <= pre + PRE_ONE;
                if (tick) begin
                    dp   <= ~dp;
                    step <= step_next;
                end
            end
        end
    end

    assign uo_out  = {dp, seg_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_seven_segment_fun.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_fun
//
// Self-checking bench for seven_segment_fun with DIV_BASE = 2. Every driven
// cycle advances a behavioural model of the display and pushes the expected
// uo_out into a scoreboard queue; each scenario task pops and compares after
// the clock edge.
// ---------------------------------------------------------------------------
module tb_seven_segment_fun;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];

    // Behavioural model state (5-bit prescaler for DIV_BASE = 2).
    int         m_pre  = 0;
    int         m_step = 0;
    logic [1:0] m_mode = 2'b00;
    logic       m_dp   = 1'b0;

    logic [6:0] hex_tab   [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] ring_tab  [6]  = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20};
    logic [6:0] snake_tab [8]  = '{7'h01, 7'h02, 7'h40, 7'h10, 7'h08, 7'h04, 7'h40, 7'h20};

    seven_segment_fun #(.DIV_BASE(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model_pattern(input logic [1:0] mode, input int step,
                                                 input logic [3:0] digit);
        case (mode)
            2'b00:   return hex_tab[digit];
            2'b01:   return hex_tab[step];
            2'b10:   return ring_tab[step];
            default: return snake_tab[step];
        endcase
    endfunction

    // Drives one cycle of stimulus, advances the model from its pre-edge
    // state, queues the expected output and waits until just after the edge.
    // Unused inputs get random values every cycle.
    task automatic applyStimulus(input logic [7:0] ui, input logic rst_val);
        int         period;
        logic [6:0] seg_exp;
        ui_in  = ui;
        rst_n  = rst_val;
        ena    = 1'($urandom);
        uio_in = 8'($urandom);
        if (!rst_val) begin
            m_pre  = 0;
            m_step = 0;
            m_mode = 2'b00;
            m_dp   = 1'b0;
            sb.push_back(8'h00);
        end else begin
            seg_exp = model_pattern(m_mode, m_step, ui[3:0]);
            period  = 1 << (2 + int'(ui[5:4]));
            if (ui[7:6] != m_mode) begin
                m_mode = ui[7:6];
                m_step = 0;
                m_pre  = 0;
            end else begin
                if ((m_pre % period) == period - 1) begin
                    m_dp = ~m_dp;
                    case (m_mode)
                        2'b00:   m_step = 0;
                        2'b01:   m_step = (m_step + 1) % 16;
                        2'b10:   m_step = (m_step + 1) % 6;
                        default: m_step = (m_step + 1) % 8;
                    endcase
                end
                m_pre = (m_pre + 1) % 32;
            end
            sb.push_back({m_dp, seg_exp});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hFF, 1'b0);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL reset_uo_out got %h want %h", uo_out, exp);
            end
            checks++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_uio got out=%h oe=%h want 00/00", uio_out, uio_oe);
            end
        end
    endtask

    task automatic test_static();
        logic [7:0] exp;
        applyStimulus(8'h00, 1'b1);
        exp = sb.pop_front();
        checks++;
        if (uo_out !== 8'h3F || uo_out !== exp) begin
            errors++;
            $display("[TB] FAIL first_after_reset got %h want 3f (model %h)", uo_out, exp);
        end
        for (int d = 0; d < 20; d++) begin
            applyStimulus({4'h0, 4'(d)}, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL static_digit%0d got %h want %h", d % 16, uo_out, exp);
            end
        end
    endtask

    task automatic test_counter();
        logic [7:0] exp;
        logic [6:0] prev_seg;
        logic       wrapped;
        prev_seg = 7'h00;
        wrapped  = 1'b0;
        for (int i = 0; i < 72; i++) begin
            applyStimulus({4'h4, 4'($urandom)}, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL counter_cycle%0d got %h want %h", i, uo_out, exp);
            end
            if (prev_seg == 7'h71 && uo_out[6:0] == 7'h3F) wrapped = 1'b1;
            prev_seg = uo_out[6:0];
        end
        checks++;
        if (wrapped !== 1'b1) begin
            errors++;
            $display("[TB] FAIL counter_wrap got %b want 1", wrapped);
        end
    endtask

    task automatic test_ring();
        logic [7:0] exp;
        for (int i = 0; i < 30; i++) begin
            applyStimulus({4'h8, 4'($urandom)}, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL ring_cycle%0d got %h want %h", i, uo_out, exp);
            end
        end
    endtask

    task automatic test_speed();
        logic [7:0] exp;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(8'h70, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL speed3_cycle%0d got %h want %h", i, uo_out, exp);
            end
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'h40, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL speed0_cycle%0d got %h want %h", i, uo_out, exp);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] exp;
        logic       dp_before;
        int         guard;
        guard = 0;
        applyStimulus(8'hC0, 1'b1);
        exp = sb.pop_front();
        checks++;
        if (uo_out !== exp) begin
            errors++;
            $display("[TB] FAIL snake_enter got %h want %h", uo_out, exp);
        end
        while (m_step != 5 && guard < 100) begin
            applyStimulus(8'hC0, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL snake_cycle%0d got %h want %h", guard, uo_out, exp);
            end
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("[TB] FAIL snake_reach_step5 got timeout want step 5");
        end
        dp_before = uo_out[7];
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h80, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL switch_cycle%0d got %h want %h", i, uo_out, exp);
            end
            if (i == 0) begin
                checks++;
                if (uo_out[7] !== dp_before) begin
                    errors++;
                    $display("[TB] FAIL switch_dp got %b want %b", uo_out[7], dp_before);
                end
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if (uo_out[6:0] !== 7'h01) begin
                    errors++;
                    $display("[TB] FAIL switch_ring_start got %h want 01", uo_out[6:0]);
                end
            end
        end
    endtask

    task automatic test_midreset();
        logic [7:0] exp;
        applyStimulus(8'h40, 1'b0);
        exp = sb.pop_front();
        checks++;
        if (uo_out !== 8'h00 || uo_out !== exp) begin
            errors++;
            $display("[TB] FAIL midreset got %h want 00", uo_out);
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'h40, 1'b1);
            exp = sb.pop_front();
            checks++;
            if (uo_out !== exp) begin
                errors++;
                $display("[TB] FAIL post_reset_cycle%0d got %h want %h", i, uo_out, exp);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'hFF;
        uio_in = 8'h00;
        $display("[TB] start");
        test_reset();
        test_static();
        test_counter();
        test_ring();
        test_speed();
        test_mode_switch();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
